// File: rtl/cpu65xx_pkg.sv
// rtl/cpu65xx_pkg.sv - shared types and constants for the cpu65xx bus responder
package cpu65xx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [15:0] VEC_NMI_ADDR  = 16'hFFFA;
    localparam logic [15:0] VEC_RST_ADDR  = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR  = 16'hFFFE;
    localparam logic [7:0]  BUS_ERR_RDATA = 8'hFF;

endpackage

// File: rtl/cpu65xx_vec_decode.sv
// rtl/cpu65xx_vec_decode.sv - hit detect and byte select for the FFFA-FFFF vector override
module cpu65xx_vec_decode
    import cpu65xx_pkg::*;
(
    input  logic [15:0] addr_i,
    input  logic        rd_i,
    input  logic        en_i,
    input  logic [15:0] vec_nmi_i,
    input  logic [15:0] vec_rst_i,
    input  logic [15:0] vec_irq_i,
    output logic        hit_o,
    output logic [7:0]  byte_o
);

    logic [15:0] sel_vec;

    always_comb begin
        sel_vec = vec_nmi_i;
        if (addr_i[15:1] == VEC_RST_ADDR[15:1]) begin
            sel_vec = vec_rst_i;
        end else if (addr_i[15:1] == VEC_IRQ_ADDR[15:1]) begin
            sel_vec = vec_irq_i;
        end
        hit_o  = en_i && rd_i && (addr_i >= VEC_NMI_ADDR);
        // 6502 vectors are little-endian: even address carries the low byte
        byte_o = addr_i[0] ? sel_vec[15:8] : sel_vec[7:0];
    end

endmodule

// File: rtl/cpu65xx_bus_responder.sv
// rtl/cpu65xx_bus_responder.sv - CPU bus target bridging cycles to a req/ack memory port
module cpu65xx_bus_responder
    import cpu65xx_pkg::*;
#(
    parameter int pAddrWidth = 16,
    parameter int pMinWait   = 0,
    parameter int pTimeout   = 15,
    parameter int pVecOvrEn  = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  CpuValid,
    input  logic [pAddrWidth-1:0] CpuAddr,
    input  logic                  CpuW_n,
    input  logic [7:0]            CpuWdata,
    output logic [7:0]            CpuRdata,
    output logic                  CpuRdy,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [pAddrWidth-1:0] MemAddr,
    output logic [7:0]            MemWdata,
    input  logic [7:0]            MemRdata,
    input  logic                  MemAck,
    input  logic                  VecOvr,
    input  logic [15:0]           VecNmi,
    input  logic [15:0]           VecRst,
    input  logic [15:0]           VecIrq,
    output logic                  BusErr,
    input  logic                  ErrClr
);

    localparam int TW = (pTimeout > 0) ? $clog2(pTimeout + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(pTimeout);
    localparam logic [3:0]    WAIT_LAST = 4'((pMinWait > 0) ? pMinWait - 1 : 0);

    state_e                  state_q, state_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic                    rd_q, rd_d;
    logic [pAddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [TW-1:0]           tmo_inc;
    logic [3:0]              wait_q, wait_d;
    logic                    err_set;
    logic                    vec_hit;
    logic [7:0]              vec_byte;

    generate
        if (pVecOvrEn != 0) begin : g_vec
            cpu65xx_vec_decode u_vec_decode (
                .addr_i    (CpuAddr[15:0]),
                .rd_i      (CpuW_n),
                .en_i      (VecOvr),
                .vec_nmi_i (VecNmi),
                .vec_rst_i (VecRst),
                .vec_irq_i (VecIrq),
                .hit_o     (vec_hit),
                .byte_o    (vec_byte)
            );
        end else begin : g_no_vec
            assign vec_hit  = 1'b0;
            assign vec_byte = 8'h00;
        end
    endgenerate

    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;
        err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CpuValid) begin
                    addr_d  = CpuAddr;
                    wdata_d = CpuWdata;
                    rd_d    = CpuW_n;
                    if (vec_hit) begin
                        rdata_d = vec_byte;
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = ~CpuW_n;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // an ack arriving on the expiry cycle takes priority over the timeout
                if (MemAck) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    tmo_d = '0;
                    if (rd_q) begin
                        rdata_d = MemRdata;
                    end
                    state_d = (pMinWait > 0) ? ST_WAIT : ST_DONE;
                end else if (pTimeout != 0) begin
                    if (tmo_inc == TMO_LIMIT) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        tmo_d   = '0;
                        err_set = 1'b1;
                        if (rd_q) begin
                            rdata_d = BUS_ERR_RDATA;
                        end
                        state_d = ST_DONE;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = err_set | (err_q & ~ErrClr);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 8'h00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
        end
    end

    assign CpuRdy   = ((state_q == ST_IDLE) && !CpuValid) || (state_q == ST_DONE);
    assign CpuRdata = rdata_q;
    assign MemReq   = req_q;
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemWdata = wdata_q;
    assign BusErr   = err_q;

endmodule

// File: tb/tb_cpu65xx_bus_responder.sv
// tb/tb_cpu65xx_bus_responder.sv - directed scoreboard bench for cpu65xx_bus_responder
module tb_cpu65xx_bus_responder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        CpuValid = 1'b0;
    logic        Valid2 = 1'b0;
    logic [15:0] CpuAddr = 16'h0000;
    logic        CpuW_n = 1'b1;
    logic [7:0]  CpuWdata = 8'h00;
    logic [7:0]  MemRdata = 8'h00;
    logic        MemAck = 1'b0;
    logic        Ack2 = 1'b0;
    logic        VecOvr = 1'b0;
    logic [15:0] VecNmi = 16'hBEEF;
    logic [15:0] VecRst = 16'hC012;
    logic [15:0] VecIrq = 16'h5A69;
    logic        ErrClr = 1'b0;

    logic [7:0]  CpuRdata, Rdata2;
    logic        CpuRdy, Rdy2;
    logic        MemReq, Req2;
    logic        MemWe, We2;
    logic [15:0] MemAddr, Addr2;
    logic [7:0]  MemWdata, Wdata2;
    logic        BusErr, Err2;

    typedef struct {
        logic [7:0] rdata;
        int         cycles;
        int         reqs;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 Clk = ~Clk;

    cpu65xx_bus_responder #(.pAddrWidth(16), .pMinWait(0), .pTimeout(15), .pVecOvrEn(1)) dut (
        .Clk(Clk), .Rst(Rst), .CpuValid(CpuValid), .CpuAddr(CpuAddr), .CpuW_n(CpuW_n),
        .CpuWdata(CpuWdata), .CpuRdata(CpuRdata), .CpuRdy(CpuRdy), .MemReq(MemReq),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemRdata(MemRdata),
        .MemAck(MemAck), .VecOvr(VecOvr), .VecNmi(VecNmi), .VecRst(VecRst),
        .VecIrq(VecIrq), .BusErr(BusErr), .ErrClr(ErrClr)
    );

    cpu65xx_bus_responder #(.pAddrWidth(16), .pMinWait(3), .pTimeout(15), .pVecOvrEn(1)) dut_wait (
        .Clk(Clk), .Rst(Rst), .CpuValid(Valid2), .CpuAddr(CpuAddr), .CpuW_n(CpuW_n),
        .CpuWdata(CpuWdata), .CpuRdata(Rdata2), .CpuRdy(Rdy2), .MemReq(Req2),
        .MemWe(We2), .MemAddr(Addr2), .MemWdata(Wdata2), .MemRdata(MemRdata),
        .MemAck(Ack2), .VecOvr(VecOvr), .VecNmi(VecNmi), .VecRst(VecRst),
        .VecIrq(VecIrq), .BusErr(Err2), .ErrClr(ErrClr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one CPU cycle on instance inst; MemAck fires on REQ cycle ack_at (-1 = never).
    task automatic bus_cycle(input string tag, input int inst, input logic [15:0] addr,
                             input logic w_n, input logic [7:0] wdata, input int ack_at,
                             input logic [7:0] mrdata, input logic [7:0] exp_rdata,
                             input int exp_cycles, input int exp_reqs, input logic exp_err);
        exp_t e;
        int   n;
        int   reqs;
        logic done;
        logic attr_bad;
        logic req, we, rdy;
        logic [15:0] maddr;
        logic [7:0]  mwdata;
        logic [7:0]  got_rdata;
        sb.push_back('{exp_rdata, exp_cycles, exp_reqs, exp_err});
        CpuAddr  = addr;
        CpuW_n   = w_n;
        CpuWdata = wdata;
        MemRdata = mrdata;
        if (inst == 0) CpuValid = 1'b1;
        else           Valid2   = 1'b1;
        n = 0; reqs = 0; done = 1'b0; attr_bad = 1'b0; got_rdata = 8'h00;
        while (!done && n < 60) begin
            n++;
            req    = (inst == 0) ? MemReq   : Req2;
            we     = (inst == 0) ? MemWe    : We2;
            maddr  = (inst == 0) ? MemAddr  : Addr2;
            mwdata = (inst == 0) ? MemWdata : Wdata2;
            if (req) begin
                reqs++;
                if (we !== ~w_n || maddr !== addr || mwdata !== wdata) attr_bad = 1'b1;
                if (inst == 0) MemAck = (reqs == ack_at);
                else           Ack2   = (reqs == ack_at);
            end
            // CPU inputs are scrambled mid-transaction; the latched values must be used
            if (n == 2) begin
                CpuAddr  = ~addr;
                CpuWdata = ~wdata;
                CpuW_n   = ~w_n;
            end
            #1;
            rdy = (inst == 0) ? CpuRdy : Rdy2;
            if (rdy) begin
                done = 1'b1;
                got_rdata = (inst == 0) ? CpuRdata : Rdata2;
            end
            @(posedge Clk);
            @(negedge Clk);
            MemAck = 1'b0;
            Ack2   = 1'b0;
        end
        CpuValid = 1'b0;
        Valid2   = 1'b0;
        CpuW_n   = 1'b1;
        e = sb.pop_front();
        check({tag, "_done"},   {31'd0, done}, 32'd1);
        check({tag, "_cycles"}, n, e.cycles);
        check({tag, "_reqs"},   reqs, e.reqs);
        check({tag, "_rdata"},  {24'd0, got_rdata}, {24'd0, e.rdata});
        check({tag, "_attr"},   {31'd0, attr_bad}, 32'd0);
        check({tag, "_err"},    {31'd0, (inst == 0) ? BusErr : Err2}, {31'd0, e.err});
    endtask

    initial begin
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        check("rst_rdy",   {31'd0, CpuRdy},   32'd1);
        check("rst_rdata", {24'd0, CpuRdata}, 32'h00);
        check("rst_req",   {31'd0, MemReq},   32'd0);
        check("rst_we",    {31'd0, MemWe},    32'd0);
        check("rst_addr",  {16'd0, MemAddr},  32'h0000);
        check("rst_wdata", {24'd0, MemWdata}, 32'h00);
        check("rst_err",   {31'd0, BusErr},   32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        bus_cycle("rd1234", 0, 16'h1234, 1'b1, 8'h00, 1, 8'hA5, 8'hA5, 3, 1, 1'b0);
        bus_cycle("wr0200", 0, 16'h0200, 1'b0, 8'h3C, 4, 8'h99, 8'hA5, 6, 4, 1'b0);

        VecOvr = 1'b1;
        bus_cycle("vec_fffc", 0, 16'hFFFC, 1'b1, 8'h00, 1, 8'h11, 8'h12, 2, 0, 1'b0);
        bus_cycle("vec_fffd", 0, 16'hFFFD, 1'b1, 8'h00, 1, 8'h11, 8'hC0, 2, 0, 1'b0);
        bus_cycle("vec_fffa", 0, 16'hFFFA, 1'b1, 8'h00, 1, 8'h11, 8'hEF, 2, 0, 1'b0);
        bus_cycle("vec_ffff", 0, 16'hFFFF, 1'b1, 8'h00, 1, 8'h11, 8'h5A, 2, 0, 1'b0);
        bus_cycle("vec_fff9", 0, 16'hFFF9, 1'b1, 8'h00, 1, 8'h77, 8'h77, 3, 1, 1'b0);
        bus_cycle("vec_wr",   0, 16'hFFFC, 1'b0, 8'h44, 1, 8'h00, 8'h77, 3, 1, 1'b0);
        VecOvr = 1'b0;
        bus_cycle("novec",    0, 16'hFFFE, 1'b1, 8'h00, 1, 8'h33, 8'h33, 3, 1, 1'b0);

        bus_cycle("tmo",      0, 16'h4000, 1'b1, 8'h00, -1, 8'h00, 8'hFF, 17, 15, 1'b1);
        ErrClr = 1'b1;
        @(negedge Clk);
        ErrClr = 1'b0;
        check("errclr", {31'd0, BusErr}, 32'd0);
        bus_cycle("ack15",    0, 16'h4001, 1'b1, 8'h00, 15, 8'h5C, 8'h5C, 17, 15, 1'b0);

        bus_cycle("minwait",  1, 16'h0300, 1'b1, 8'h00, 1, 8'h81, 8'h81, 6, 1, 1'b0);

        bus_cycle("tmo2",     0, 16'h4002, 1'b1, 8'h00, -1, 8'h00, 8'hFF, 17, 15, 1'b1);

        CpuAddr = 16'h5000; CpuW_n = 1'b1; CpuValid = 1'b1;
        repeat (3) @(negedge Clk);
        check("mid_req", {31'd0, MemReq}, 32'd1);
        Rst = 1'b1;
        CpuValid = 1'b0;
        @(negedge Clk);
        check("rstmid_req",   {31'd0, MemReq},   32'd0);
        check("rstmid_rdy",   {31'd0, CpuRdy},   32'd1);
        check("rstmid_err",   {31'd0, BusErr},   32'd0);
        check("rstmid_rdata", {24'd0, CpuRdata}, 32'h00);
        Rst = 1'b0;
        MemAck = 1'b1;
        MemRdata = 8'hEE;
        @(negedge Clk);
        MemAck = 1'b0;
        @(negedge Clk);
        check("late_ack_rdata", {24'd0, CpuRdata}, 32'h00);
        check("late_ack_req",   {31'd0, MemReq},   32'd0);
        check("late_ack_rdy",   {31'd0, CpuRdy},   32'd1);
        bus_cycle("recover",  0, 16'h1000, 1'b1, 8'h00, 2, 8'h42, 8'h42, 4, 2, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu65xx_bus_responder.md
Name: cpu65xx_bus_responder

Overview:
- Target-side responder for the cpu65xx core bus.
- Accepts CPU bus cycles (address, R/W, write data) and answers with read data and RDY wait-state control.
- Bridges each cycle to a req/ack backing-memory port, with optional timeout and a hardware vector override for FFFA-FFFF.
- Sits between the CPU core and the system memory/peripheral fabric.

Parameters:
- pAddrWidth, 16, width of CpuAddr and MemAddr.
- pMinWait, 0, extra CPU wait cycles inserted after MemAck (0..15).
- pTimeout, 15, REQ cycles without MemAck before bus error; 0 disables timeout.
- pVecOvrEn, 1, 1 instantiates the vector override path; 0 removes it.

Ports:
- Clk  in  1  single clock.
- Rst  in  1  reset, synchronous, active-high.
- CpuValid  in  1  CPU presents a valid bus cycle (VDA|VPA).
- CpuAddr  in  pAddrWidth  CPU address.
- CpuW_n  in  1  0 = write, 1 = read.
- CpuWdata  in  8  CPU write data.
- CpuRdata  out  8  read data, valid when CpuRdy=1.
- CpuRdy  out  1  1 = current cycle completes at this edge.
- MemReq  out  1  backing memory request, registered.
- MemWe  out  1  write enable, registered.
- MemAddr  out  pAddrWidth  latched address.
- MemWdata  out  8  latched write data.
- MemRdata  in  8  memory read data, valid with MemAck.
- MemAck  in  1  one-cycle completion strobe.
- VecOvr  in  1  enable vector override at runtime.
- VecNmi  in  16  NMI vector (FFFA/FFFB).
- VecRst  in  16  reset vector (FFFC/FFFD).
- VecIrq  in  16  IRQ/BRK vector (FFFE/FFFF).
- BusErr  out  1  sticky timeout flag.
- ErrClr  in  1  clears BusErr.

Behaviour:
- Reset values: state IDLE, CpuRdata 0x00, MemReq 0, MemWe 0, MemAddr 0, MemWdata 0, BusErr 0, counters 0. CpuRdy is 1 in reset, since IDLE with CpuValid=0.
- CpuRdy is combinational: 1 when (IDLE and CpuValid=0) or state==DONE; 0 otherwise.
- IDLE, CpuValid=1:
  - Latch CpuAddr, CpuW_n, CpuWdata.
  - Vector hit (pVecOvrEn=1, VecOvr=1, read, addr[15:0] in FFFA..FFFF): load CpuRdata from the matching vector byte (even address = low byte) and go to DONE. Total 2 cycles; no MemReq.
  - Otherwise go to REQ with MemReq=1, MemWe=~CpuW_n from the next cycle.
- REQ:
  - MemReq is held until MemAck. On MemAck, MemReq drops at the next edge.
  - Read: capture MemRdata into CpuRdata.
  - Next state: WAIT if pMinWait>0, else DONE.
  - Timeout counter increments each REQ cycle without MemAck. When it reaches pTimeout: drop MemReq, set BusErr, CpuRdata=0xFF (read), go to DONE.
  - MemAck in the same cycle as expiry: ack wins, no error.
- WAIT: count pMinWait cycles, then DONE.
- DONE: CpuRdy=1 for exactly one cycle, then IDLE. A new CpuValid is accepted only from IDLE, so back-to-back cycles cost one IDLE cycle.
- Minimum memory latency: ack in the first REQ cycle gives 3 cycles (IDLE, REQ, DONE).
- CPU inputs changing during REQ/WAIT are ignored; latched values are used.
- MemAck outside REQ is ignored.
- Timeout error writes are discarded.
- ErrClr clears BusErr; a simultaneous new error wins (BusErr stays 1).
- Rst mid-operation: all registers return to reset values at that edge. MemReq is 0 from the next cycle; any later MemAck is ignored.
- Timeout counter width is clog2(pTimeout+1). Wait counter is 4 bits. Neither counter wraps; both clear on state exit.

Decomposition:
- Package cpu65xx_pkg:
  - State enum (IDLE, REQ, WAIT, DONE).
  - Vector address constants (FFFA, FFFC, FFFE).
  - Bus-error read value 8'hFF.
- One sub-module: cpu65xx_vec_decode, a combinational hit detector plus byte select for the override vectors.

Test Plan:
- Read 0x1234, MemAck in first REQ cycle with MemRdata=0xA5, pMinWait=0 -> CpuRdy low 2 cycles, high on cycle 3, CpuRdata=0xA5, MemReq high exactly 1 cycle.
- Write 0x0200 data 0x3C, MemAck after 4 cycles -> MemWe=1, MemAddr=0x0200, MemWdata=0x3C held 4 cycles; CpuRdy pulses once.
- VecOvr=1, VecRst=0xC012, reads at FFFC then FFFD -> CpuRdata 0x12 then 0xC0, each in 2 cycles, MemReq never asserted.
- pTimeout=15, no MemAck -> MemReq drops after 15 REQ cycles, BusErr=1, CpuRdata=0xFF; ErrClr pulse -> BusErr=0. MemAck on cycle 15 -> no error.
- pMinWait=3, immediate ack -> CpuRdy asserted 6 cycles after accept.
- Assert Rst during REQ -> MemReq=0 next cycle, state IDLE, BusErr=0, CpuRdy=1; late MemAck ignored.
